// File: rtl/alu_seq_if.sv
// Operand/result bundle between the datapath controller (master) and the
// sequential ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       ALUop;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUout;
  logic [WIDTH-1:0] HI;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;

  modport master (
    output start, ALUop, A, B,
    input  busy, done, ALUout, HI, N, Z, C, V
  );

  modport slave (
    input  start, ALUop, A, B,
    output busy, done, ALUout, HI, N, Z, C, V
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative unsigned MUL
// (shift-add, LSB first) and DIV (restoring, MSB first), start/busy/done.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      CLOCK_50,
  input logic      RESET,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_OR, OP_NAND, OP_SHL, OP_SHR, OP_MUL, OP_DIV
  } op_t;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam int               MSB     = WIDTH - 1;

  state_t           state, state_n;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] p_hi, p_lo;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] res_q, hi_q;
  logic             n_q, z_q, c_q, v_q;

  logic accept, iter_in, load;
  assign accept  = bus.start && (state == IDLE || state == DONE);
  assign iter_in = bus.ALUop[2] & bus.ALUop[1];
  assign load    = (state == EXEC) || (state == ITER && cnt == '0);

  // ---------------- FSM: state register ----------------
  // NOTE: clocked state is always assigned with <= so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = accept ? (iter_in ? ITER : EXEC) : IDLE;
      EXEC:       state_n = DONE;
      ITER:       if (cnt == '0) state_n = DONE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  logic busy_s, done_s;
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    unique case (state)
      EXEC, ITER: busy_s = 1'b1;
      DONE:       done_s = 1'b1;
      default:    ;
    endcase
  end

  // ---------------- one iteration step ----------------
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
    div_sh  = {p_hi, p_lo[MSB]};
    div_ge  = div_sh >= {1'b0, b_q};
    if (op_q == OP_DIV) begin
      // When div_ge the true remainder is below B, so W-bit subtraction is exact.
      step_hi = div_ge ? (div_sh[MSB:0] - b_q) : div_sh[MSB:0];
      step_lo = {p_lo[MSB-1:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], p_lo[MSB:1]};
    end
  end

  // ---------------- result selection ----------------
  logic [WIDTH:0]   sum_x, dif_x;
  logic             shift_big;
  logic [WIDTH-1:0] res_d, hi_d;
  logic             c_d, v_d;
  always_comb begin
    sum_x     = {1'b0, a_q} + {1'b0, b_q};
    dif_x     = {1'b0, a_q} - {1'b0, b_q};
    shift_big = b_q >= WIDTH_V;
    res_d     = '0;
    hi_d      = '0;
    c_d       = 1'b0;
    v_d       = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res_d = sum_x[MSB:0];
        c_d   = sum_x[WIDTH];
        v_d   = (a_q[MSB] == b_q[MSB]) && (sum_x[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_d = dif_x[MSB:0];
        c_d   = ~dif_x[WIDTH];
        v_d   = (a_q[MSB] != b_q[MSB]) && (dif_x[MSB] != a_q[MSB]);
      end
      OP_OR:   res_d = a_q | b_q;
      OP_NAND: res_d = ~(a_q & b_q);
      OP_SHL:  res_d = shift_big ? '0 : (a_q << b_q);
      OP_SHR:  res_d = shift_big ? '0 : (a_q >> b_q);
      OP_MUL: begin
        res_d = step_lo;
        hi_d  = step_hi;
        c_d   = |step_hi;
        v_d   = |step_hi;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_d = '1;
          hi_d  = a_q;
          c_d   = 1'b1;
          v_d   = 1'b1;
        end else begin
          res_d = step_lo;
          hi_d  = step_hi;
        end
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  // NOTE: these are individual registers, not a memory, so all are reset;
  // Z is cleared too rather than recomputed from the zeroed result.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
      res_q <= '0;
      hi_q  <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op_t'(bus.ALUop);
        a_q  <= bus.A;
        b_q  <= bus.B;
        cnt  <= SHW'(WIDTH - 1);
        p_hi <= '0;
        p_lo <= (op_t'(bus.ALUop) == OP_DIV) ? bus.A : bus.B;
      end else if (state == ITER) begin
        cnt  <= cnt - 1'b1;
        p_hi <= step_hi;
        p_lo <= step_lo;
      end
      if (load) begin
        res_q <= res_d;
        hi_q  <= hi_d;
        n_q   <= res_d[MSB];
        z_q   <= (res_d == '0);
        c_q   <= c_d;
        v_q   <= v_d;
      end
    end
  end

  assign bus.busy   = busy_s;
  assign bus.done   = done_s;
  assign bus.ALUout = res_q;
  assign bus.HI     = hi_q;
  assign bus.N      = n_q;
  assign bus.Z      = z_q;
  assign bus.C      = c_q;
  assign bus.V      = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an 8-bit and a 16-bit instance checked
// against an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8))  dut8  (.CLOCK_50(clk), .RESET(rst), .bus(if8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.CLOCK_50(clk), .RESET(rst), .bus(if16.slave));

  int tests_run    = 0;
  int tests_failed = 0;

  // {ALUout(16), HI(16), N, Z, C, V}
  typedef logic [35:0] obs_t;

  function automatic obs_t model(int w, logic [2:0] op, logic [15:0] a_in, logic [15:0] b_in);
    longint a, b, m, half, sa, sb, r, h;
    bit c, v;
    a    = longint'(a_in);
    b    = longint'(b_in);
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - (longint'(1) << w) : a;
    sb   = (b >= half) ? b - (longint'(1) << w) : b;
    r = 0; h = 0; c = 0; v = 0;
    case (op)
      3'd0: begin r = a + b; c = (r > m); v = (sa + sb >= half) || (sa + sb < -half); end
      3'd1: begin r = a - b; c = (a >= b); v = (sa - sb >= half) || (sa - sb < -half); end
      3'd2: r = a | b;
      3'd3: r = ~(a & b);
      3'd4: r = (b >= w) ? 0 : (a << b);
      3'd5: r = (b >= w) ? 0 : (a >> b);
      3'd6: begin r = a * b; h = r >> w; c = (h != 0); v = c; end
      default: begin
        if (b == 0) begin r = m; h = a; c = 1; v = 1; end
        else begin r = a / b; h = a % b; end
      end
    endcase
    r = r & m;
    h = h & m;
    return {r[15:0], h[15:0], r[w-1], (r == 0), c, v};
  endfunction

  function automatic obs_t observe(bit wide);
    if (wide) return {if16.ALUout, if16.HI, if16.N, if16.Z, if16.C, if16.V};
    return {8'h00, if8.ALUout, 8'h00, if8.HI, if8.N, if8.Z, if8.C, if8.V};
  endfunction

  function automatic logic o_done(bit wide);
    return wide ? if16.done : if8.done;
  endfunction

  function automatic logic o_busy(bit wide);
    return wide ? if16.busy : if8.busy;
  endfunction

  task automatic drive(bit wide, bit s, logic [2:0] op, logic [15:0] a, logic [15:0] b);
    if (wide) begin
      if16.start = s; if16.ALUop = op; if16.A = a; if16.B = b;
    end else begin
      if8.start = s; if8.ALUop = op; if8.A = a[7:0]; if8.B = b[7:0];
    end
  endtask

  task automatic drive_noise(bit wide);
    drive(wide, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // One complete operation: latency, busy length, result, done pulse width, hold.
  task automatic do_op(bit wide, logic [2:0] op, logic [15:0] a, logic [15:0] b,
                       string name, output obs_t got);
    int w, exp_lat, cyc, busy_n;
    logic [15:0] am, bm;
    obs_t exp;
    w       = wide ? 16 : 8;
    exp_lat = (op >= 3'd6) ? w + 1 : 2;
    am      = wide ? a : {8'h00, a[7:0]};
    bm      = wide ? b : {8'h00, b[7:0]};
    exp     = model(w, op, am, bm);
    @(negedge clk); drive(wide, 1'b1, op, a, b);
    @(negedge clk); drive_noise(wide);
    cyc = 1; busy_n = 0;
    while (!o_done(wide) && cyc < 40) begin
      if (o_busy(wide)) busy_n++;
      @(negedge clk); cyc++;
    end
    got = observe(wide);
    tests_run++;
    if (cyc !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
    end
    tests_run++;
    if (busy_n !== exp_lat - 1) begin
      tests_failed++;
      $display("FAIL %s busy_len: got %0d, expected %0d", name, busy_n, exp_lat - 1);
    end
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s result op=%0d a=%h b=%h: got %h expected %h", name, op, am, bm, got, exp);
    end
    @(negedge clk);
    tests_run++;
    if (o_done(wide) !== 1'b0 || observe(wide) !== exp) begin
      tests_failed++;
      $display("FAIL %s hold: done=%b out=%h expected done=0 out=%h", name, o_done(wide), observe(wide), exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (observe(1'b0) !== '0 || o_busy(1'b0) !== 1'b0 || o_done(1'b0) !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset8: out=%h busy=%b done=%b expected all 0", observe(1'b0), o_busy(1'b0), o_done(1'b0));
    end
    tests_run++;
    if (observe(1'b1) !== '0 || o_busy(1'b1) !== 1'b0 || o_done(1'b1) !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset16: out=%h busy=%b done=%b expected all 0", observe(1'b1), o_busy(1'b1), o_done(1'b1));
    end
    rst = 1'b0;
  endtask

  typedef struct {
    bit          wide;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    obs_t        exp;
  } dir_t;

  task automatic test_directed();
    dir_t tbl[10];
    obs_t got;
    tbl[0] = '{1'b0, 3'd0, 16'h7F,   16'h01,   {16'h0080, 16'h0000, 4'b1001}};
    tbl[1] = '{1'b0, 3'd1, 16'h05,   16'h05,   {16'h0000, 16'h0000, 4'b0110}};
    tbl[2] = '{1'b0, 3'd1, 16'h03,   16'h05,   {16'h00FE, 16'h0000, 4'b1000}};
    tbl[3] = '{1'b0, 3'd6, 16'h12,   16'h34,   {16'h00A8, 16'h0003, 4'b1011}};
    tbl[4] = '{1'b0, 3'd7, 16'd200,  16'd7,    {16'h001C, 16'h0004, 4'b0000}};
    tbl[5] = '{1'b0, 3'd7, 16'h2A,   16'h00,   {16'h00FF, 16'h002A, 4'b1011}};
    tbl[6] = '{1'b0, 3'd4, 16'h81,   16'h01,   {16'h0002, 16'h0000, 4'b0000}};
    tbl[7] = '{1'b0, 3'd5, 16'h80,   16'h08,   {16'h0000, 16'h0000, 4'b0100}};
    tbl[8] = '{1'b0, 3'd3, 16'hFF,   16'hFF,   {16'h0000, 16'h0000, 4'b0100}};
    tbl[9] = '{1'b1, 3'd6, 16'h1234, 16'h0010, {16'h2340, 16'h0001, 4'b0011}};
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].wide, tbl[i].op, tbl[i].a, tbl[i].b, $sformatf("dir%0d", i), got);
      tests_run++;
      if (got !== tbl[i].exp) begin
        tests_failed++;
        $display("FAIL dir%0d literal: got %h expected %h", i, got, tbl[i].exp);
      end
    end
  endtask

  task automatic test_random();
    obs_t got;
    logic [15:0] b;
    for (int i = 0; i < 50; i++) begin
      bit wide;
      wide = (i % 5 == 4);
      b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 18)) : 16'($urandom);
      do_op(wide, 3'($urandom), 16'($urandom), b, $sformatf("rnd%0d", i), got);
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] a, b;
    obs_t exp;
    int cyc, extra;
    a = 8'($urandom); b = 8'($urandom);
    exp = model(8, 3'd6, {8'h00, a}, {8'h00, b});
    @(negedge clk); drive(1'b0, 1'b1, 3'd6, {8'h00, a}, {8'h00, b});
    @(negedge clk); drive_noise(1'b0);
    cyc = 1;
    repeat (2) begin @(negedge clk); cyc++; end
    drive(1'b0, 1'b1, 3'($urandom), 16'($urandom), 16'($urandom));
    @(negedge clk); cyc++;
    drive_noise(1'b0);
    while (!o_done(1'b0) && cyc < 40) begin @(negedge clk); cyc++; end
    tests_run++;
    if (cyc !== 9 || observe(1'b0) !== exp) begin
      tests_failed++;
      $display("FAIL ignore_start: cyc=%0d out=%h expected cyc=9 out=%h", cyc, observe(1'b0), exp);
    end
    extra = 0;
    repeat (12) begin @(negedge clk); if (o_done(1'b0) || o_busy(1'b0)) extra++; end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL ignore_queued: got %0d active cycles, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [2:0] op1, op2;
      logic [7:0] a1, b1, a2, b2;
      obs_t exp1, exp2;
      int cyc;
      op1 = 3'($urandom); op2 = 3'($urandom_range(0, 5));
      a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
      exp1 = model(8, op1, {8'h00, a1}, {8'h00, b1});
      exp2 = model(8, op2, {8'h00, a2}, {8'h00, b2});
      @(negedge clk); drive(1'b0, 1'b1, op1, {8'h00, a1}, {8'h00, b1});
      @(negedge clk); drive_noise(1'b0);
      cyc = 1;
      while (!o_done(1'b0) && cyc < 40) begin @(negedge clk); cyc++; end
      tests_run++;
      if (o_done(1'b0) !== 1'b1 || observe(1'b0) !== exp1) begin
        tests_failed++;
        $display("FAIL b2b%0d first: done=%b out=%h expected done=1 out=%h", i, o_done(1'b0), observe(1'b0), exp1);
      end
      drive(1'b0, 1'b1, op2, {8'h00, a2}, {8'h00, b2});
      @(negedge clk); drive_noise(1'b0);
      tests_run++;
      if (o_busy(1'b0) !== 1'b1 || o_done(1'b0) !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b%0d gap: busy=%b done=%b expected busy=1 done=0", i, o_busy(1'b0), o_done(1'b0));
      end
      @(negedge clk);
      tests_run++;
      if (o_done(1'b0) !== 1'b1 || observe(1'b0) !== exp2) begin
        tests_failed++;
        $display("FAIL b2b%0d second: done=%b out=%h expected done=1 out=%h", i, o_done(1'b0), observe(1'b0), exp2);
      end
    end
  endtask

  task automatic test_reset_midop();
    obs_t got;
    int extra;
    do_op(1'b0, 3'd2, 16'h5A, 16'h0F, "pre_rst", got);
    @(negedge clk); drive(1'b0, 1'b1, 3'd6, 16'hFF, 16'hFF);
    @(negedge clk); drive_noise(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (observe(1'b0) !== '0 || o_busy(1'b0) !== 1'b0 || o_done(1'b0) !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid8: out=%h busy=%b done=%b expected all 0", observe(1'b0), o_busy(1'b0), o_done(1'b0));
    end
    tests_run++;
    if (observe(1'b1) !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid16: out=%h expected 0", observe(1'b1));
    end
    @(negedge clk); rst = 1'b0;
    extra = 0;
    repeat (12) begin @(negedge clk); if (o_done(1'b0) || o_busy(1'b0)) extra++; end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL rst_no_done: got %0d active cycles, expected 0", extra);
    end
    do_op(1'b0, 3'd0, 16'd2, 16'd3, "post_rst_add", got);
    tests_run++;
    if (got !== {16'h0005, 16'h0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL post_rst_literal: got %h expected %h", got, {16'h0005, 16'h0000, 4'b0000});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
